app_sequencer: RTL
==================

APP_SEQUENCER -- requirements
Module: app_sequencer

Interface
REQ-001 The module SHALL have parameter TIMEOUT_TICKS, default 1500, meaning the number of tick pulses without a button press before the idle timeout fires (30 s at 50 Hz).
REQ-002 The module SHALL have port clk, input, 1 bit: the system clock; every register is clocked on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port tick, input, 1 bit: a one-cycle enable pulse at 50 Hz that advances the idle counter.
REQ-005 The module SHALL have port btn_in, input, 5 bits: debounced single-cycle button pulses, ordered {C,U,D,L,R}.
REQ-006 The module SHALL have port pw_flag, input, 1 bit: the passcode-accepted level.
REQ-007 The module SHALL have port menu_sel, input, 3 bits: the application currently highlighted in the menu.
REQ-008 The module SHALL have port app_id, output, 3 bits: 0 = menu/lock, 1 = peak, 2 = pong, 3 = wave, 4 = tetris.
REQ-009 The module SHALL have port app_en, output, 4 bits: one-hot enable for apps 1..4 (bit 0 = app 1).
REQ-010 The module SHALL have ports btn_pw, btn_menu and btn_app, each output, 5 bits: the button pulses routed to the passcode block, the menu and the active app respectively.
REQ-011 The module SHALL have port locked, output, 1 bit: high while in LOCKED.
REQ-012 The module SHALL have port timeout, output, 1 bit: a one-cycle pulse when the idle timeout fires.

Function
REQ-013 The FSM SHALL have exactly four states: LOCKED, MENU, APP and LEAVE.
REQ-014 In LOCKED, pw_flag=1 SHALL move the FSM to MENU on the next cycle.
REQ-015 In MENU, a btn_in[C] pulse with menu_sel in 1..4 SHALL move the FSM to APP and latch app_id = menu_sel.
- menu_sel = 0 or menu_sel > 4: the pulse is ignored.
REQ-016 In MENU, btn_in[L] and btn_in[R] asserted in the same cycle SHALL move the FSM to LOCKED.
REQ-017 In APP, a btn_in[C] pulse SHALL move the FSM to LEAVE; that C pulse is consumed and is not routed to btn_app.
REQ-018 LEAVE SHALL last exactly one cycle with all btn_* outputs zero, then move to MENU with app_id = 0.
REQ-019 Button routing SHALL be registered with 1-cycle latency.
- Only the owner of the current state receives pulses: LOCKED -> btn_pw, MENU -> btn_menu, APP -> btn_app.
- All non-owner outputs are 0.
- Routing uses the state before the transition, so the pulse that causes a transition is never forwarded to the new owner.
REQ-020 app_en SHALL equal one-hot(app_id - 1) only in APP, and SHALL be 0 in all other states.
REQ-021 The idle counter SHALL be TIMEOUT_TICKS-wide-enough and saturating.
- Any nonzero btn_in clears it to 0.
- Otherwise it increments on tick.
- State changes also clear it.
REQ-022 When the idle counter reaches TIMEOUT_TICKS, the FSM SHALL take the idle transition: APP -> LEAVE, MENU -> LOCKED.
- timeout pulses for one cycle.
- The counter clears.
- LOCKED never times out.
REQ-023 Priority in a single cycle SHALL be: reset > button-caused transition > timeout.
- A button press in the same cycle as a timeout suppresses the timeout.
REQ-024 In LOCKED, pw_flag SHALL be ignored while btn_pw is pulsing in the same cycle; the transition is taken the following cycle if the flag is still high.

Reset
REQ-025 Reset SHALL force:
- state = LOCKED, app_id = 0, app_en = 0
- btn_pw = btn_menu = btn_app = 0
- locked = 1, timeout = 0
- idle counter = 0
REQ-026 Reset asserted mid-APP SHALL drop app_en in the same edge, with no LEAVE cycle.

Configuration
REQ-027 With macro IDLE_TIMEOUT_EN defined, REQ-021 and REQ-022 SHALL apply.
REQ-028 Without IDLE_TIMEOUT_EN:
- The counter is not implemented.
- timeout is tied to 0.
- Transitions happen only by button or pw_flag.

Structure
REQ-029 The following SHALL live in the shared definitions header:
- state encodings and app_id encodings
- button bit indices BTN_C/U/D/L/R
- APP_COUNT = 4
REQ-030 The idle counter SHALL be the sub-module idle_timer (inputs: clk, reset, tick, clr; output: expired).

Verification
REQ-031 The bench SHALL cover reset then pw_flag=1 -> locked falls and state = MENU after 1 cycle; btn_pw pulses only while LOCKED.
REQ-032 The bench SHALL cover MENU with menu_sel=2 and btn_in=C -> app_id=2, app_en=4'b0010; the following btn_in=U appears on btn_app[U] 1 cycle later, and btn_menu stays 0.
REQ-033 The bench SHALL cover APP with btn_in=C -> exactly 1 LEAVE cycle with all btn_* = 0, then MENU with app_id=0; btn_app[C] never pulses.
REQ-034 The bench SHALL cover TIMEOUT_TICKS=4 in APP with no buttons -> timeout pulses after the 4th tick, then LEAVE, then MENU; after 4 more idle ticks -> LOCKED.
REQ-035 The bench SHALL cover a btn_in=U pulse coincident with the 4th tick -> no timeout, and the counter restarts from 0.
REQ-036 The bench SHALL cover MENU with menu_sel=5 and btn_in=C -> remains in MENU with app_id=0; then L+R together -> LOCKED.

Source files
------------

// File: rtl/app_sequencer_pkg.sv
// Shared definitions for the application sequencer: FSM state codes, app_id codes,
// button bit positions {C,U,D,L,R} and small helpers for app_id decoding.
// Pure definitions: no latency, no flow control.
package app_sequencer_pkg;

    localparam int APP_COUNT = 4;
    localparam int BTN_W     = 5;

    typedef logic [BTN_W-1:0] btn_t;

    typedef enum logic [1:0] {
        ST_LOCKED = 2'd0,
        ST_MENU   = 2'd1,
        ST_APP    = 2'd2,
        ST_LEAVE  = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        APP_MENU   = 3'd0,
        APP_PEAK   = 3'd1,
        APP_PONG   = 3'd2,
        APP_WAVE   = 3'd3,
        APP_TETRIS = 3'd4
    } app_e;

    // Bit positions inside btn_in and the routed button buses.
    typedef enum int {
        BTN_R = 0,
        BTN_L = 1,
        BTN_D = 2,
        BTN_U = 3,
        BTN_C = 4
    } btn_idx_e;

    // True when the id names a real application (not the menu/lock screen).
    function automatic logic app_id_valid(input logic [2:0] id);
        return (id >= APP_PEAK) && (id <= APP_TETRIS);
    endfunction

    // Enable vector for apps 1..APP_COUNT, bit 0 = app 1; all-zero for invalid ids.
    function automatic logic [APP_COUNT-1:0] app_onehot(input logic [2:0] id);
        logic [APP_COUNT-1:0] r;
        r = '0;
        for (int i = 0; i < APP_COUNT; i++) begin
            r[i] = (id == 3'(i + 1));
        end
        return r;
    endfunction

endpackage

// File: rtl/app_sequencer_if.sv
// Bundle between the sequencer and the rest of the UI: tick, buttons, passcode flag and
// menu selection in; app selection, app enables, routed buttons, lock and timeout out.
// master = UI/environment side, slave = sequencer side; pulses only, no backpressure.
interface app_sequencer_if;
    import app_sequencer_pkg::*;

    logic                 tick;
    btn_t                 btn_in;
    logic                 pw_flag;
    logic [2:0]           menu_sel;
    logic [2:0]           app_id;
    logic [APP_COUNT-1:0] app_en;
    btn_t                 btn_pw;
    btn_t                 btn_menu;
    btn_t                 btn_app;
    logic                 locked;
    logic                 timeout;

    modport master (
        output tick, btn_in, pw_flag, menu_sel,
        input  app_id, app_en, btn_pw, btn_menu, btn_app, locked, timeout
    );

    modport slave (
        input  tick, btn_in, pw_flag, menu_sel,
        output app_id, app_en, btn_pw, btn_menu, btn_app, locked, timeout
    );

endinterface

// File: rtl/app_sequencer_idle_timer.sv
// Saturating idle counter: counts tick pulses, flags expired once TIMEOUT_TICKS is reached.
// Latency: expired rises the cycle after the counting tick; clr takes effect on the next edge.
// No backpressure; clr has priority over tick. Ports: clk, reset, tick, clr in; expired out.
module idle_timer #(
    parameter int TIMEOUT_TICKS = 1500
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic clr,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_TICKS < 2) ? 1 : $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_TICKS);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/app_sequencer.sv
// Top-level UI sequencer: LOCKED/MENU/APP/LEAVE FSM that owns app selection and routes
// button pulses to the passcode block, menu or active app (1-cycle registered routing).
// No backpressure: buttons are pulses, dropped when their owner is not active.
// Ports: clk, reset (sync, active-high) and bus (app_sequencer_if.slave).
// Optional feature: define IDLE_TIMEOUT_EN to build the idle timer (timeout = 0 otherwise).
module app_sequencer
    import app_sequencer_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 1500
) (
    input  logic           clk,
    input  logic           reset,
    app_sequencer_if.slave bus
);

    state_e               state_q, state_d;
    logic [2:0]           app_id_q, app_id_d;
    btn_t                 btn_pw_q, btn_pw_d;
    btn_t                 btn_menu_q, btn_menu_d;
    btn_t                 btn_app_q, btn_app_d;
    logic [APP_COUNT-1:0] app_en;
    logic                 locked;

    logic any_btn;
    logic c_press;
    logic lr_press;
    logic idle_fire;

    assign any_btn  = |bus.btn_in;
    assign c_press  = bus.btn_in[BTN_C];
    assign lr_press = bus.btn_in[BTN_L] && bus.btn_in[BTN_R];

`ifdef IDLE_TIMEOUT_EN
    logic idle_clr;
    logic idle_expired;

    // Any activity restarts the idle period, as does every state change.
    assign idle_clr = any_btn || (state_d != state_q);

    idle_timer #(
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_idle_timer (
        .clk     (clk),
        .reset   (reset),
        .tick    (bus.tick),
        .clr     (idle_clr),
        .expired (idle_expired)
    );

    // A button in the same cycle outranks the timeout; LOCKED/LEAVE never time out.
    assign idle_fire = idle_expired && !any_btn &&
                       ((state_q == ST_MENU) || (state_q == ST_APP));
`else
    logic unused_tick;
    assign unused_tick = bus.tick & (TIMEOUT_TICKS > 0);
    assign idle_fire   = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_LOCKED;
            app_id_q   <= APP_MENU;
            btn_pw_q   <= '0;
            btn_menu_q <= '0;
            btn_app_q  <= '0;
        end else begin
            state_q    <= state_d;
            app_id_q   <= app_id_d;
            btn_pw_q   <= btn_pw_d;
            btn_menu_q <= btn_menu_d;
            btn_app_q  <= btn_app_d;
        end
    end

    // Next state. Button-caused transitions are tested before the idle timeout.
    always_comb begin
        state_d  = state_q;
        app_id_d = app_id_q;
        case (state_q)
            ST_LOCKED: begin
                // The flag is held off while the passcode block is still being fed a
                // pulse, so a late keypress cannot race the unlock.
                if (bus.pw_flag && (btn_pw_q == '0)) begin
                    state_d = ST_MENU;
                end
            end
            ST_MENU: begin
                if (c_press && app_id_valid(bus.menu_sel)) begin
                    state_d  = ST_APP;
                    app_id_d = bus.menu_sel;
                end else if (lr_press) begin
                    state_d = ST_LOCKED;
                end else if (idle_fire) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_APP: begin
                if (c_press || idle_fire) begin
                    state_d = ST_LEAVE;
                end
            end
            ST_LEAVE: begin
                state_d  = ST_MENU;
                app_id_d = APP_MENU;
            end
            default: begin
                state_d  = ST_LOCKED;
                app_id_d = APP_MENU;
            end
        endcase
    end

    // Outputs. Routing looks at the current (pre-transition) state, so a pulse that
    // causes a transition goes to the old owner. The C that exits an app is swallowed,
    // which also keeps the routed buses quiet for the whole LEAVE cycle.
    always_comb begin
        btn_pw_d   = '0;
        btn_menu_d = '0;
        btn_app_d  = '0;
        app_en     = '0;
        locked     = 1'b0;
        case (state_q)
            ST_LOCKED: begin
                btn_pw_d = bus.btn_in;
                locked   = 1'b1;
            end
            ST_MENU: begin
                btn_menu_d = bus.btn_in;
            end
            ST_APP: begin
                if (!c_press) begin
                    btn_app_d = bus.btn_in;
                end
                app_en = app_onehot(app_id_q);
            end
            default: begin
                btn_pw_d = '0;
            end
        endcase
    end

    assign bus.app_id   = app_id_q;
    assign bus.app_en   = app_en;
    assign bus.btn_pw   = btn_pw_q;
    assign bus.btn_menu = btn_menu_q;
    assign bus.btn_app  = btn_app_q;
    assign bus.locked   = locked;
    assign bus.timeout  = idle_fire;

endmodule
